// File: rtl/alu_shift_pkg.sv
// Shared mode encoding and shifter-control decode for the ALU rotate/shift datapath.
package alu_shift_pkg;

    localparam int MODE_W = 3;
    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_ROL = 3'd0;
    localparam mode_t MODE_ROR = 3'd1;
    localparam mode_t MODE_SLL = 3'd2;
    localparam mode_t MODE_SRL = 3'd3;
    localparam mode_t MODE_SRA = 3'd4;
    localparam mode_t MODE_RCL = 3'd5;
    localparam mode_t MODE_RCR = 3'd6;
    localparam mode_t MODE_ILL = 3'd7;

    // hi_align: operand sits in the upper WIDTH bits so bit 0 catches the last bit shifted out.
    typedef struct packed {
        logic left;
        logic rot;
        logic ring_w1;
        logic hi_align;
    } shift_ctl_t;

    function automatic shift_ctl_t decode_mode(input mode_t mode);
        shift_ctl_t ctl;
        ctl = '0;
        case (mode)
            MODE_ROL: begin ctl.left = 1'b1; ctl.rot = 1'b1; end
            MODE_ROR: begin ctl.rot = 1'b1; end
            MODE_SLL: begin ctl.left = 1'b1; end
            MODE_SRL,
            MODE_SRA: begin ctl.hi_align = 1'b1; end
            MODE_RCL: begin ctl.left = 1'b1; ctl.rot = 1'b1; ctl.ring_w1 = 1'b1; end
            MODE_RCR: begin ctl.rot = 1'b1; ctl.ring_w1 = 1'b1; end
            default: ;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/rot_shift_layer.sv
// Combinational log-shifter layers on a (WIDTH+1)-bit word; layer k moves by 2**(BASE+k).
module rot_shift_layer #(
    parameter int WIDTH = 16,
    parameter int NBITS = 1,
    parameter int BASE  = 0
) (
    input  logic [WIDTH:0]   word_i,
    input  logic [NBITS-1:0] amt_i,
    input  logic             left_i,
    input  logic             rot_i,
    input  logic             ring_w1_i,
    input  logic             fill_i,
    output logic [WIDTH:0]   word_o
);

    logic [NBITS:0][WIDTH:0] stg;

    assign stg[0] = word_i;

    for (genvar k = 0; k < NBITS; k++) begin : g_layer
        localparam int S = 1 << (BASE + k);

        logic [WIDTH:0] x;
        logic [WIDTH:0] rol_w1, rol_w, shl, ror_w1, ror_w, shr, moved;

        assign x = stg[k];

        // Width-WIDTH rotates leave bit WIDTH untouched; width-(WIDTH+1) rotates include it.
        assign rol_w1 = {x[WIDTH-S:0], x[WIDTH:WIDTH-S+1]};
        assign rol_w  = {x[WIDTH], x[WIDTH-1-S:0], x[WIDTH-1:WIDTH-S]};
        assign shl    = {x[WIDTH-S:0], {S{fill_i}}};
        assign ror_w1 = {x[S-1:0], x[WIDTH:S]};
        assign ror_w  = {x[WIDTH], x[S-1:0], x[WIDTH-1:S]};
        assign shr    = {{S{fill_i}}, x[WIDTH:S]};

        assign moved = left_i ? (rot_i ? (ring_w1_i ? rol_w1 : rol_w) : shl)
                              : (rot_i ? (ring_w1_i ? ror_w1 : ror_w) : shr);

        assign stg[k+1] = amt_i[k] ? moved : x;
    end

    assign word_o = stg[NBITS];

endmodule

// File: rtl/barrel_rotator_pipe.sv
// Two-stage elastic rotate/shift unit: S1 applies the coarse amount, S2 the fine amount plus flags.
module barrel_rotator_pipe
    import alu_shift_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(WIDTH)-1:0]   in_amt,
    input  logic [2:0]                 in_mode,
    input  logic                       in_cin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_cout,
    output logic                       out_zero,
    output logic                       out_err
);

    localparam int AMT_W    = $clog2(WIDTH);
    localparam int COARSE_W = AMT_W / 2;
    localparam int FINE_W   = AMT_W - COARSE_W;

    logic               s1_v_q, s1_v_d;
    logic               s2_v_q, s2_v_d;
    logic [WIDTH:0]     s1_word_q;
    logic [FINE_W-1:0]  s1_fine_q;
    mode_t              s1_mode_q;
    logic               s1_nz_q;
    logic [WIDTH-1:0]   out_data_q;
    logic               out_cout_q, out_zero_q, out_err_q;

    logic               s2_en, accept, advance;
    shift_ctl_t         ctl_in, ctl_s2;
    logic [WIDTH:0]     word_in, coarse_word, fine_word;
    logic               fill_in, fill_s2;
    logic [WIDTH-1:0]   res_data;
    logic               res_cout, res_err;

    assign s2_en    = !s2_v_q || out_ready;
    assign in_ready = !s1_v_q || s2_en;
    assign accept   = in_valid && in_ready;
    assign advance  = s1_v_q && s2_en;

    always_comb begin
        s1_v_d = s1_v_q;
        s2_v_d = s2_v_q;
        if (accept)     s1_v_d = 1'b1;
        else if (s2_en) s1_v_d = 1'b0;
        if (s2_en)      s2_v_d = s1_v_q;
    end

    // ---- S1: frame the operand and apply the upper amount bits
    assign ctl_in  = decode_mode(mode_t'(in_mode));
    assign fill_in = (mode_t'(in_mode) == MODE_SRA) && in_data[WIDTH-1];
    assign word_in = ctl_in.hi_align ? {in_data, 1'b0}
                                     : {ctl_in.ring_w1 & in_cin, in_data};

    rot_shift_layer #(.WIDTH(WIDTH), .NBITS(COARSE_W), .BASE(FINE_W)) u_coarse (
        .word_i    (word_in),
        .amt_i     (in_amt[AMT_W-1:FINE_W]),
        .left_i    (ctl_in.left),
        .rot_i     (ctl_in.rot),
        .ring_w1_i (ctl_in.ring_w1),
        .fill_i    (fill_in),
        .word_o    (coarse_word)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_word_q <= coarse_word;
            s1_fine_q <= in_amt[FINE_W-1:0];
            s1_mode_q <= mode_t'(in_mode);
            s1_nz_q   <= |in_amt;
        end
    end

    // ---- S2: apply the lower amount bits, extract result and flags
    assign ctl_s2  = decode_mode(s1_mode_q);
    assign fill_s2 = (s1_mode_q == MODE_SRA) && s1_word_q[WIDTH];

    rot_shift_layer #(.WIDTH(WIDTH), .NBITS(FINE_W), .BASE(0)) u_fine (
        .word_i    (s1_word_q),
        .amt_i     (s1_fine_q),
        .left_i    (ctl_s2.left),
        .rot_i     (ctl_s2.rot),
        .ring_w1_i (ctl_s2.ring_w1),
        .fill_i    (fill_s2),
        .word_o    (fine_word)
    );

    always_comb begin
        res_data = ctl_s2.hi_align ? fine_word[WIDTH:1] : fine_word[WIDTH-1:0];
        res_cout = 1'b0;
        res_err  = 1'b0;
        case (s1_mode_q)
            MODE_ROL: res_cout = s1_nz_q & res_data[0];
            MODE_ROR: res_cout = s1_nz_q & res_data[WIDTH-1];
            MODE_SLL,
            MODE_RCL,
            MODE_RCR: res_cout = fine_word[WIDTH];
            MODE_SRL,
            MODE_SRA: res_cout = fine_word[0];
            default: begin
                res_data = '0;
                res_err  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q     <= 1'b0;
            s2_v_q     <= 1'b0;
            out_data_q <= '0;
            out_cout_q <= 1'b0;
            out_zero_q <= 1'b0;
            out_err_q  <= 1'b0;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
            if (advance) begin
                out_data_q <= res_data;
                out_cout_q <= res_cout;
                out_zero_q <= (res_data == '0);
                out_err_q  <= res_err;
            end
        end
    end

    assign out_valid = s2_v_q;
    assign out_data  = out_data_q;
    assign out_cout  = out_cout_q;
    assign out_zero  = out_zero_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_barrel_rotator_pipe.sv
// Bench for barrel_rotator_pipe (WIDTH=16): arithmetic reference model, scoreboard and directed vectors.
module tb_barrel_rotator_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_amt;
    logic [2:0]  in_mode;
    logic        in_cin;
    logic        out_valid, out_ready;
    logic [15:0] out_data;
    logic        out_cout, out_zero, out_err;

    int checks   = 0;
    int failures = 0;
    int pop_cnt  = 0;

    typedef struct packed {
        logic        err;
        logic        zero;
        logic        cout;
        logic [15:0] data;
    } res_t;

    res_t exp_q[$];
    res_t cur_res, exp_res, prev_res;
    logic prev_stall = 1'b0;

    always #5 clk = ~clk;

    barrel_rotator_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cout  (out_cout),
        .out_zero  (out_zero),
        .out_err   (out_err)
    );

    function automatic res_t model(input logic [15:0] d, input int a, input logic [2:0] m, input logic c);
        res_t        r;
        logic [31:0] dd, w;
        logic [16:0] wr;
        dd = {16'b0, d};
        w  = {15'b0, c, d};
        r  = '0;
        case (m)
            3'd0: begin r.data = 16'((dd << a) | (dd >> (16 - a))); r.cout = (a != 0) && r.data[0];  end
            3'd1: begin r.data = 16'((dd >> a) | (dd << (16 - a))); r.cout = (a != 0) && r.data[15]; end
            3'd2: begin r.data = 16'(dd << a); r.cout = (a != 0) ? d[16 - a] : 1'b0; end
            3'd3: begin r.data = d >> a;       r.cout = (a != 0) ? d[a - 1] : 1'b0; end
            3'd4: begin r.data = 16'($signed(d) >>> a); r.cout = (a != 0) ? d[a - 1] : 1'b0; end
            3'd5: begin wr = 17'((w << a) | (w >> (17 - a))); r.data = wr[15:0]; r.cout = wr[16]; end
            3'd6: begin wr = 17'((w >> a) | (w << (17 - a))); r.data = wr[15:0]; r.cout = wr[16]; end
            default: begin r.data = '0; r.cout = 1'b0; r.err = 1'b1; end
        endcase
        r.zero = (r.data == 16'h0);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every result in order, plus output hold while stalled.
    always @(negedge clk) begin
        cur_res = {out_err, out_zero, out_cout, out_data};
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("hold_stable", 32'({out_valid, cur_res}), 32'({1'b1, prev_res}));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got %h expected no beat", cur_res);
                end else begin
                    exp_res = exp_q.pop_front();
                    chk("result", 32'(cur_res), 32'(exp_res));
                end
                pop_cnt++;
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(in_data, int'(in_amt), in_mode, in_cin));
            prev_stall = out_valid && !out_ready;
            prev_res   = cur_res;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_lit(input string name, input logic [15:0] d, input int a, input logic [2:0] m,
                            input logic c, input logic [15:0] ed, input logic ec, input logic ez,
                            input logic ee);
        int lat;
        lat = 0;
        tick();
        in_data = d; in_amt = 4'(a); in_mode = m; in_cin = c; in_valid = 1'b1; out_ready = 1'b1;
        #1 chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i + 1;
                break;
            end
        end
        chk({name, "_latency"}, 32'(lat), 32'd2);
        chk(name, 32'({out_err, out_zero, out_cout, out_data}), 32'({ee, ez, ec, ed}));
    endtask

    task automatic send_beat(input logic [15:0] d, input int a, input logic [2:0] m, input logic c);
        logic acc;
        int   guard;
        acc   = 1'b0;
        guard = 0;
        if ($urandom_range(3) == 0) begin
            tick();
            in_valid  = 1'b0;
            in_data   = 16'($urandom);
            out_ready = 1'($urandom_range(1));
        end
        while (!acc && guard < 50) begin
            tick();
            in_valid = 1'b1; in_data = d; in_amt = 4'(a); in_mode = m; in_cin = c;
            out_ready = ($urandom_range(3) != 0);
            #1 acc = in_ready;
            guard++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got in_ready 0 for %0d cycles expected acceptance", guard);
        end
    endtask

    initial begin
        int pc;
        int guard;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0; in_cin = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({out_valid, out_err, out_zero, out_cout, out_data}), 32'd0);
        rst_n = 1'b1;
        tick();
        #1 chk("reset_in_ready", 32'({in_ready, out_valid}), 32'b10);

        send_lit("rol_8001_1",  16'h8001, 1,  3'd0, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0);
        send_lit("ror_0001_4",  16'h0001, 4,  3'd1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        send_lit("ror_0001_1",  16'h0001, 1,  3'd1, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b0);
        send_lit("sra_8000_15", 16'h8000, 15, 3'd4, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        send_lit("srl_8000_15", 16'h8000, 15, 3'd3, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0);
        send_lit("sll_0003_15", 16'h0003, 15, 3'd2, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b0);
        send_lit("sll_amt0",    16'h8000, 0,  3'd2, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b0);
        send_lit("rcr_0001_c1", 16'h0001, 1,  3'd6, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b0);
        send_lit("rcl_8000_c0", 16'h8000, 1,  3'd5, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        send_lit("rcl_amt0_c1", 16'h1234, 0,  3'd5, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
        send_lit("illegal",     16'hFFFF, 3,  3'd7, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1);
        send_lit("after_ill",   16'h1234, 0,  3'd0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);

        // Backpressure: two beats fill the pipe, the third waits.
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h00F0; in_amt = 4'd4; in_mode = 3'd0; in_cin = 1'b0;
        #1 chk("bp_accept_a", 32'(in_ready), 32'd1);
        tick();
        in_data = 16'hF000; in_amt = 4'd12; in_mode = 3'd4;
        #1 chk("bp_accept_b", 32'(in_ready), 32'd1);
        tick();
        in_data = 16'h0101; in_amt = 4'd8; in_mode = 3'd1;
        #1 chk("bp_full", 32'(in_ready), 32'd0);
        repeat (3) begin
            tick();
            #1 chk("bp_stall", 32'({in_ready, out_valid}), 32'b01);
        end
        tick();
        out_ready = 1'b1;
        pc = pop_cnt;
        tick();
        in_valid = 1'b0;
        chk("bp_drain1", 32'(pop_cnt - pc), 32'd1);
        tick();
        chk("bp_drain2", 32'(pop_cnt - pc), 32'd2);
        tick();
        chk("bp_drain3", 32'(pop_cnt - pc), 32'd3);

        // Reset with two beats in flight.
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'hAAAA; in_amt = 4'd3; in_mode = 3'd2;
        tick();
        in_data = 16'h5555; in_amt = 4'd5; in_mode = 3'd3;
        tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("rst_flush", 32'({out_valid, out_data}), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) begin
            tick();
            #1 chk("no_stale", 32'(out_valid), 32'd0);
        end

        // Sweep every mode and amount, then random beats, under random backpressure.
        for (int m = 0; m < 8; m++)
            for (int a = 0; a < 16; a++)
                send_beat(16'($urandom), a, 3'(m), 1'($urandom_range(1)));
        for (int i = 0; i < 200; i++)
            send_beat(16'($urandom), int'($urandom_range(15)), 3'($urandom_range(7)),
                      1'($urandom_range(1)));
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            tick();
            guard++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

endmodule
